// File: rtl/wb_interconnect_nslave_pkg.sv
// Shared types and helpers for the single-master, N-slave Wishbone interconnect.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_ACK  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // Index field width; a single-slave build still keeps a 1-bit field so the
  // decoder can flag any set bit above the slave region as unmapped.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_interconnect_nslave_addr_decode.sv
// Combinational address decode: master address -> slave index and mapped flag.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned WB_WIDTH      = 16,
  parameter int unsigned N_SLAVES      = 4,
  parameter int unsigned SLV_ADDR_BITS = 12
) (
  input  logic [WB_WIDTH-1:0]           adr_i,
  output logic [idx_w(N_SLAVES)-1:0]    idx_o,
  output logic                          mapped_o
);

  localparam int unsigned IDX_W = idx_w(N_SLAVES);

  logic [WB_WIDTH-1:0] field;
  logic [WB_WIDTH-1:0] upper;

  always_comb begin
    field    = adr_i >> SLV_ADDR_BITS;
    upper    = field >> IDX_W;
    idx_o    = field[IDX_W-1:0];
    mapped_o = (upper == '0) && (32'(idx_o) < N_SLAVES);
  end

endmodule

// File: rtl/wb_interconnect_nslave.sv
// Single-master, N-slave Wishbone classic interconnect with registered request,
// registered ACK/ERR response, per-transfer timeout and saturating error counter.
module wb_interconnect_nslave
  import wb_pkg::*;
#(
  parameter int unsigned WB_WIDTH      = 16,
  parameter int unsigned WB_W_DATA     = 8,
  parameter int unsigned N_SLAVES      = 4,
  parameter int unsigned SLV_ADDR_BITS = 12,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                          CLK_i,
  input  logic                          RST_i,
  input  logic [WB_WIDTH-1:0]           M_ADR_i,
  input  logic [WB_W_DATA-1:0]          M_DAT_i,
  input  logic                          M_WE_i,
  input  logic                          M_STB_i,
  input  logic                          M_CYC_i,
  output logic [WB_W_DATA-1:0]          M_DAT_o,
  output logic                          M_ACK_o,
  output logic                          M_ERR_o,
  output logic [WB_WIDTH-1:0]           S_ADR_o,
  output logic [WB_W_DATA-1:0]          S_DAT_o,
  output logic                          S_WE_o,
  output logic [N_SLAVES-1:0]           S_CYC_o,
  output logic [N_SLAVES-1:0]           S_STB_o,
  input  logic [N_SLAVES*WB_W_DATA-1:0] S_DAT_i,
  input  logic [N_SLAVES-1:0]           S_ACK_i,
  input  logic [N_SLAVES-1:0]           S_ERR_i,
  output logic [7:0]                    ERR_CNT_o
);

  localparam int unsigned IDX_W = idx_w(N_SLAVES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [WB_WIDTH-1:0] ADR_ONES   = '1;
  localparam logic [WB_WIDTH-1:0] LOCAL_MASK = ADR_ONES >> (WB_WIDTH - SLV_ADDR_BITS);

  wb_state_e             state_q, state_d;
  logic [WB_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_W_DATA-1:0]  wdat_q, wdat_d;
  logic                  we_q, we_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [WB_W_DATA-1:0]  rdat_q, rdat_d;
  logic [7:0]            errcnt_q, errcnt_d;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_mapped;
  logic [N_SLAVES-1:0]   req_sel;
  logic [WB_W_DATA-1:0]  sel_rdat;
  logic                  sel_ack;
  logic                  sel_err;

  wb_addr_decode #(
    .WB_WIDTH      (WB_WIDTH),
    .N_SLAVES      (N_SLAVES),
    .SLV_ADDR_BITS (SLV_ADDR_BITS)
  ) u_decode (
    .adr_i    (M_ADR_i),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped)
  );

  always_comb begin
    req_sel = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (dec_idx == IDX_W'(k)) req_sel[k] = 1'b1;
    end
  end

  // The latched select is one-hot, so OR-ing the masked slices picks the owner.
  always_comb begin
    sel_rdat = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (sel_q[k]) sel_rdat |= S_DAT_i[k*WB_W_DATA +: WB_W_DATA];
    end
  end

  assign sel_ack = |(S_ACK_i & sel_q);
  assign sel_err = |(S_ERR_i & sel_q);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    resp_d  = RESP_NONE;
    rdat_d  = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (M_CYC_i && M_STB_i) begin
          adr_d  = M_ADR_i & LOCAL_MASK;
          wdat_d = M_DAT_i;
          we_d   = M_WE_i;
          if (dec_mapped) begin
            sel_d   = req_sel;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            resp_d  = RESP_ERR;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Abort wins over any response; ERR wins over ACK; ACK over timeout.
        if (!M_CYC_i) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_err) begin
          sel_d   = '0;
          resp_d  = RESP_ERR;
          state_d = ST_RESP;
        end else if (sel_ack) begin
          sel_d   = '0;
          rdat_d  = sel_rdat;
          resp_d  = RESP_ACK;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          sel_d   = '0;
          resp_d  = RESP_ERR;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (resp_d == RESP_ERR && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      wdat_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      resp_q   <= RESP_NONE;
      rdat_q   <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      resp_q   <= resp_d;
      rdat_q   <= rdat_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign S_ADR_o   = adr_q;
  assign S_DAT_o   = wdat_q;
  assign S_WE_o    = we_q;
  assign S_CYC_o   = sel_q;
  assign S_STB_o   = sel_q;
  assign M_DAT_o   = rdat_q;
  assign M_ACK_o   = (resp_q == RESP_ACK);
  assign M_ERR_o   = (resp_q == RESP_ERR);
  assign ERR_CNT_o = errcnt_q;

endmodule

// File: tb/tb_wb_interconnect_nslave.sv
// Bench for wb_interconnect_nslave: a per-cycle expected timeline built from the
// transfer timing rules, checked against the DUT on every falling edge.
module tb_wb_interconnect_nslave;

  localparam int unsigned TO = 16;
  localparam int NEXP = 4096;
  localparam logic [31:0] SDAT_BG = 32'hD3C2B1A0;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3, K_ABORT = 4;

  logic        clk = 1'b0;
  logic        RST_i;
  logic [15:0] M_ADR_i;
  logic [7:0]  M_DAT_i;
  logic        M_WE_i, M_STB_i, M_CYC_i;
  logic [7:0]  M_DAT_o;
  logic        M_ACK_o, M_ERR_o;
  logic [15:0] S_ADR_o;
  logic [7:0]  S_DAT_o;
  logic        S_WE_o;
  logic [3:0]  S_CYC_o, S_STB_o;
  logic [31:0] S_DAT_i;
  logic [3:0]  S_ACK_i, S_ERR_i;
  logic [7:0]  ERR_CNT_o;

  wb_interconnect_nslave #(
    .WB_WIDTH      (16),
    .WB_W_DATA     (8),
    .N_SLAVES      (4),
    .SLV_ADDR_BITS (12),
    .TIMEOUT       (TO)
  ) dut (
    .CLK_i     (clk),
    .RST_i     (RST_i),
    .M_ADR_i   (M_ADR_i),
    .M_DAT_i   (M_DAT_i),
    .M_WE_i    (M_WE_i),
    .M_STB_i   (M_STB_i),
    .M_CYC_i   (M_CYC_i),
    .M_DAT_o   (M_DAT_o),
    .M_ACK_o   (M_ACK_o),
    .M_ERR_o   (M_ERR_o),
    .S_ADR_o   (S_ADR_o),
    .S_DAT_o   (S_DAT_o),
    .S_WE_o    (S_WE_o),
    .S_CYC_o   (S_CYC_o),
    .S_STB_o   (S_STB_o),
    .S_DAT_i   (S_DAT_i),
    .S_ACK_i   (S_ACK_i),
    .S_ERR_i   (S_ERR_i),
    .ERR_CNT_o (ERR_CNT_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;
  int m_errcnt = 0;
  int stb2_cnt = 0;

  // Expected outputs for the interval following rising edge k.
  logic [3:0]  exp_sel  [NEXP];
  logic [1:0]  exp_resp [NEXP];
  logic [15:0] exp_adr  [NEXP];
  logic [7:0]  exp_wdat [NEXP];
  logic        exp_we   [NEXP];
  logic [7:0]  exp_rdat [NEXP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (RST_i) begin
      m_errcnt = 0;
    end else if (cyc < NEXP) begin
      if (exp_resp[cyc] == 2'd2 && m_errcnt != 255) m_errcnt++;
      chk("s_stb",   32'(S_STB_o), 32'(exp_sel[cyc]));
      chk("s_cyc",   32'(S_CYC_o), 32'(exp_sel[cyc]));
      chk("m_ack",   32'(M_ACK_o), 32'(exp_resp[cyc] == 2'd1));
      chk("m_err",   32'(M_ERR_o), 32'(exp_resp[cyc] == 2'd2));
      chk("err_cnt", 32'(ERR_CNT_o), 32'(m_errcnt));
      if (exp_sel[cyc] != 4'd0) begin
        chk("s_adr", 32'(S_ADR_o), 32'(exp_adr[cyc]));
        chk("s_dat", 32'(S_DAT_o), 32'(exp_wdat[cyc]));
        chk("s_we",  32'(S_WE_o),  32'(exp_we[cyc]));
      end
      if (exp_resp[cyc] == 2'd1) chk("m_dat", 32'(M_DAT_o), 32'(exp_rdat[cyc]));
      if (S_STB_o[2]) stb2_cnt++;
    end
  end

  // One master transfer plus the slave behaviour it meets. Called #1 after a
  // rising edge; returns #1 after the edge following the response/abort.
  task automatic xfer(input logic [15:0] adr, input logic [7:0] wdat, input logic we,
                      input int kind, input int n, input logic [7:0] rdat, input bit hold,
                      output int e_o, output int er_o);
    int e, er, idx;
    bit mapped;
    logic [3:0] oh;
    logic [31:0] d;
    e = cyc + 1;
    idx = int'(adr >> 12);
    mapped = (idx < 4);
    oh = mapped ? 4'(1 << idx) : 4'd0;
    d = SDAT_BG;
    if (mapped) d[idx*8 +: 8] = rdat;
    if (!mapped) er = e;
    else if (kind == K_SILENT) er = e + int'(TO);
    else if (kind == K_ABORT) er = e + n;
    else er = e + n + 1;
    if (mapped) begin
      for (int k = e; k < er; k++) begin
        exp_sel[k]  = oh;
        exp_adr[k]  = adr & 16'h0FFF;
        exp_wdat[k] = wdat;
        exp_we[k]   = we;
      end
    end
    if (!(mapped && kind == K_ABORT)) begin
      exp_resp[er] = (mapped && kind == K_ACK) ? 2'd1 : 2'd2;
      exp_rdat[er] = rdat;
    end
    M_ADR_i = adr; M_DAT_i = wdat; M_WE_i = we; M_CYC_i = 1'b1; M_STB_i = 1'b1;
    for (int k = e; k <= er; k++) begin
      @(posedge clk); #1;
      S_ACK_i = '0; S_ERR_i = '0; S_DAT_i = SDAT_BG;
      if (mapped) begin
        if ((kind == K_ACK || kind == K_BOTH) && k == e + n) begin S_ACK_i = oh; S_DAT_i = d; end
        if ((kind == K_ERR || kind == K_BOTH) && k == e + n) S_ERR_i = oh;
        if (kind == K_SILENT && k < er) begin S_ACK_i = ~oh; S_ERR_i = ~oh; end
        if (kind == K_ABORT && k == e + n - 1) begin M_CYC_i = 1'b0; M_STB_i = 1'b0; end
      end
      if (k == er && !hold) begin M_CYC_i = 1'b0; M_STB_i = 1'b0; end
    end
    @(posedge clk); #1;
    S_ACK_i = '0; S_ERR_i = '0; S_DAT_i = SDAT_BG;
    e_o = e;
    er_o = er;
  endtask

  int e, er, r1, r2;

  initial begin
    for (int i = 0; i < NEXP; i++) begin
      exp_sel[i] = '0; exp_resp[i] = '0; exp_adr[i] = '0;
      exp_wdat[i] = '0; exp_we[i] = 1'b0; exp_rdat[i] = '0;
    end
    RST_i = 1'b1;
    M_ADR_i = '0; M_DAT_i = '0; M_WE_i = 1'b0; M_STB_i = 1'b0; M_CYC_i = 1'b0;
    S_DAT_i = SDAT_BG; S_ACK_i = '0; S_ERR_i = '0;
    #1;
    chk("rst_m_ack", 32'(M_ACK_o), 32'd0);
    chk("rst_s_stb", 32'(S_STB_o), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT_o), 32'd0);
    chk("rst_m_dat", 32'(M_DAT_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 RST_i = 1'b0;
    @(posedge clk); #1;

    // Write AA to slave 1, immediate ACK.
    xfer(16'h1004, 8'hAA, 1'b1, K_ACK, 0, 8'h00, 1'b0, e, er);
    chk("t1_sel_model", 32'(exp_sel[e]), 32'h2);
    chk("t1_adr_model", 32'(exp_adr[e]), 32'h0004);
    chk("t1_latency", 32'(er - e + 1), 32'd2);

    // Read slave 3 after 3 wait cycles.
    xfer(16'h3010, 8'h00, 1'b0, K_ACK, 3, 8'h5C, 1'b0, e, er);
    chk("t2_latency", 32'(er - e + 1), 32'd5);
    chk("t2_rdat_model", 32'(exp_rdat[er]), 32'h5C);

    // Unmapped addresses.
    xfer(16'h4000, 8'h00, 1'b0, K_ACK, 0, 8'h00, 1'b0, e, er);
    chk("t3_unmapped_lat", 32'(er - e + 1), 32'd1);
    chk("t3_err_cnt1", 32'(ERR_CNT_o), 32'd1);
    xfer(16'hF000, 8'h00, 1'b0, K_ACK, 0, 8'h00, 1'b0, e, er);
    chk("t3_err_cnt2", 32'(ERR_CNT_o), 32'd2);

    // Silent slave 2, other slaves chattering.
    stb2_cnt = 0;
    xfer(16'h2ABC, 8'h11, 1'b1, K_SILENT, 0, 8'h00, 1'b0, e, er);
    chk("t4_stb2_cycles", 32'(stb2_cnt), 32'd16);
    chk("t4_err_cnt", 32'(ERR_CNT_o), 32'd3);

    // Simultaneous ACK and ERR, then plain ERR.
    xfer(16'h1100, 8'h22, 1'b0, K_BOTH, 1, 8'h99, 1'b0, e, er);
    chk("t5_err_cnt", 32'(ERR_CNT_o), 32'd4);
    xfer(16'h0FFF, 8'h33, 1'b1, K_ERR, 2, 8'h00, 1'b0, e, er);
    chk("t6_err_cnt", 32'(ERR_CNT_o), 32'd5);

    // Write to slave 3 with one wait, then abort in BUSY cycle 2.
    xfer(16'h3FFE, 8'h5A, 1'b1, K_ACK, 1, 8'h66, 1'b0, e, er);
    xfer(16'h1200, 8'h44, 1'b1, K_ABORT, 2, 8'h00, 1'b0, e, er);
    chk("t7_abort_err_cnt", 32'(ERR_CNT_o), 32'd5);

    // Reset pulse mid-BUSY.
    M_ADR_i = 16'h1234; M_DAT_i = 8'h77; M_WE_i = 1'b1; M_CYC_i = 1'b1; M_STB_i = 1'b1;
    @(posedge clk); #1;
    chk("t8_busy_stb", 32'(S_STB_o), 32'h2);
    RST_i = 1'b1;
    #1;
    chk("t8_rst_stb", 32'(S_STB_o), 32'd0);
    chk("t8_rst_cyc", 32'(S_CYC_o), 32'd0);
    chk("t8_rst_adr", 32'(S_ADR_o), 32'd0);
    chk("t8_rst_dat", 32'(S_DAT_o), 32'd0);
    chk("t8_rst_we", 32'(S_WE_o), 32'd0);
    chk("t8_rst_m_dat", 32'(M_DAT_o), 32'd0);
    chk("t8_rst_err_cnt", 32'(ERR_CNT_o), 32'd0);
    M_CYC_i = 1'b0; M_STB_i = 1'b0;
    @(posedge clk); #1 RST_i = 1'b0;
    @(posedge clk); #1;

    // Error counter saturation.
    for (int i = 0; i < 260; i++)
      xfer(16'h4000 | 16'(i), 8'h00, 1'b0, K_ACK, 0, 8'h00, 1'b0, e, er);
    chk("t9_err_cnt_sat", 32'(ERR_CNT_o), 32'd255);

    // Back-to-back reads with the request held.
    xfer(16'h0011, 8'h00, 1'b0, K_ACK, 0, 8'h3A, 1'b1, e, r1);
    xfer(16'h1FFF, 8'h00, 1'b0, K_ACK, 0, 8'hC5, 1'b0, e, r2);
    chk("t10_b2b_spacing", 32'(r2 - r1), 32'd3);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
